stage_memory: RTL and testbench
===============================

# stage_memory

Memory stage of the 5-stage pipeline, between the execute stage and writeback. Takes the execute stage's registered outputs, performs word loads/stores over a request/acknowledge data-memory port with wait-state support, stalls the pipeline while an access is outstanding, and registers the results into the writeback pipeline register. Also produces the selected writeback result `wb_result`, which feeds execute-stage forwarding and the register file.

## Interface
- `TIMEOUT_CYCLES`, 255, maximum cycles spent in WAIT before an access is force-completed with a fault (1..65535)
- `clk`  in  1  pipeline clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high; clears all state
- `wb_clear`  in  1  hazard-unit flush of the writeback register
- `mem_reg_write`  in  1  register-file write enable from execute
- `mem_mem_write`  in  1  store enable
- `mem_result_src`  in  2  result select: 00 ALU, 01 load data, 10 PC+4, 11 immediate
- `mem_alu_result`  in  32  ALU result; memory address for loads/stores
- `mem_write_data`  in  32  store data
- `mem_pc_plus_4`  in  32  link value
- `mem_imm_ext`  in  32  extended immediate
- `mem_rd`  in  5  destination register
- `dmem_rdata`  in  32  memory read data, valid when `dmem_ack`=1
- `dmem_ack`  in  1  memory completes the current request this cycle
- `dmem_req`  out  1  access request; held until ack or timeout
- `dmem_we`  out  1  1 = write, 0 = read; valid with `dmem_req`
- `dmem_addr`  out  32  equals `mem_alu_result`
- `dmem_wdata`  out  32  equals `mem_write_data`
- `mem_stall`  out  1  to hazard unit: freeze fetch/decode/execute and hold their registers
- `mem_fault`  out  1  sticky: misaligned access or timeout occurred
- `wb_reg_write`, `wb_result_src[1:0]`, `wb_alu_result[31:0]`, `wb_read_data[31:0]`, `wb_pc_plus_4[31:0]`, `wb_imm_ext[31:0]`, `wb_rd[4:0]`  out  registered writeback fields
- `wb_result`  out  32  combinational mux of registered fields by `wb_result_src`

## Operation
- access = `mem_mem_write` | (`mem_result_src`==01); aligned = `mem_alu_result[1:0]`==00.
- FSM states IDLE, WAIT. Counter `wait_cnt` (16 bits).
- IDLE: `dmem_req` = access & aligned & ~reset (combinational). If req & ack: complete, stay IDLE. If req & ~ack: `mem_stall`=1, go WAIT, `wait_cnt`<=1.
- WAIT: `dmem_req`=1, address/data/we driven from held `mem_*` inputs (upstream frozen). On ack: complete, `mem_stall`=0, go IDLE. Else if `wait_cnt`==TIMEOUT_CYCLES: force-complete, load data = 0, set `mem_fault`, go IDLE, `mem_stall`=0. Else `mem_stall`=1, `wait_cnt`++.
- Ack and timeout in the same cycle: ack wins, no fault.
- Misaligned access: no request issued, no stall, `mem_fault` set; load captures 0; store dropped.
- `dmem_ack` outside an active request is ignored.
- Writeback register update priority: reset > `wb_clear` (all fields 0) > `mem_stall` (hold all fields) > advance (capture `mem_*`; `wb_read_data` = `dmem_rdata` on acked load, else 0).
- Hold, not bubble, during stall: the writeback instruction's write repeats harmlessly and its forwarded `wb_result` stays valid for the frozen execute stage.
- `wb_result`: 00 `wb_alu_result`, 01 `wb_read_data`, 10 `wb_pc_plus_4`, 11 `wb_imm_ext`.

## Timing
- Reset: state IDLE, `wait_cnt`=0, `mem_fault`=0, all `wb_*`=0 (so `wb_result`=0), `dmem_req`=0, `mem_stall`=0.
- Zero-wait access (ack in the request cycle): no stall; result in `wb_*` on the next edge (1-cycle latency, same as non-memory ops).
- N-wait access: `mem_stall` high N cycles; `wb_*` captured on the edge ending the ack cycle; total latency N+1.
- Timeout: stall lasts exactly TIMEOUT_CYCLES cycles.
- Reset mid-WAIT: next edge returns to IDLE; `dmem_req` drops combinationally in the reset cycle.
- `wb_clear` during a stall clears `wb_*` but does not affect the FSM or the outstanding request.

## Test plan
- ALU op, `mem_result_src`=00, `mem_alu_result`=0x1234, rd=5 -> no `dmem_req`; next cycle `wb_rd`=5, `wb_result`=0x1234.
- Load addr 0x100, ack same cycle, rdata 0xDEADBEEF -> `mem_stall` never high; next cycle `wb_result`=0xDEADBEEF.
- Store addr 0x200, data 0xCAFEF00D, ack after 3 cycles -> `dmem_req`/`dmem_we` high 4 cycles, `mem_stall` high 3, `wb_*` held at the prior instruction throughout, `wb_reg_write`=0 after.
- TIMEOUT_CYCLES=4, load never acked -> stall 4 cycles, then `wb_read_data`=0, `mem_fault`=1 sticky.
- Load addr 0x102 -> no request, no stall, `mem_fault`=1, `wb_read_data`=0.
- Reset asserted in 2nd WAIT cycle -> `dmem_req`=0 that cycle; after edge IDLE, `mem_fault`=0, all `wb_*`=0.

Source files
------------

// File: rtl/stage_memory.sv
// Memory stage: word loads/stores over a req/ack data port with wait states and timeout,
// pipeline stall generation, and the writeback pipeline register with result select.
module stage_memory #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_clear,
  input  logic        mem_reg_write,
  input  logic        mem_mem_write,
  input  logic [1:0]  mem_result_src,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_write_data,
  input  logic [31:0] mem_pc_plus_4,
  input  logic [31:0] mem_imm_ext,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        mem_stall,
  output logic        mem_fault,
  output logic        wb_reg_write,
  output logic [1:0]  wb_result_src,
  output logic [31:0] wb_alu_result,
  output logic [31:0] wb_read_data,
  output logic [31:0] wb_pc_plus_4,
  output logic [31:0] wb_imm_ext,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_result
);

  localparam int unsigned CNT_W = 16;
  localparam logic [1:0]  SRC_ALU  = 2'b00;
  localparam logic [1:0]  SRC_LOAD = 2'b01;
  localparam logic [1:0]  SRC_PC4  = 2'b10;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              fault_q, fault_d;
  logic              access, aligned, acked, req, stall;
  logic [31:0]       read_data_d;

  logic              wb_reg_write_q;
  logic [1:0]        wb_result_src_q;
  logic [31:0]       wb_alu_result_q, wb_read_data_q, wb_pc_plus_4_q, wb_imm_ext_q;
  logic [4:0]        wb_rd_q;

  assign access     = mem_mem_write | (mem_result_src == SRC_LOAD);
  assign aligned    = (mem_alu_result[1:0] == 2'b00);
  assign dmem_we    = mem_mem_write;
  assign dmem_addr  = mem_alu_result;
  assign dmem_wdata = mem_write_data;

  // Access FSM: request/stall generation, wait counting and fault detection
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    fault_d    = fault_q;
    req        = 1'b0;
    stall      = 1'b0;
    acked      = 1'b0;
    case (state_q)
      S_IDLE: begin
        req = access & aligned;
        if (access & ~aligned) begin
          fault_d = 1'b1;
        end
        if (req) begin
          if (dmem_ack) begin
            acked = 1'b1;
          end else begin
            stall      = 1'b1;
            state_d    = S_WAIT;
            wait_cnt_d = CNT_W'(1);
          end
        end
      end
      S_WAIT: begin
        req = 1'b1;
        if (dmem_ack) begin
          acked      = 1'b1;
          state_d    = S_IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          fault_d    = 1'b1;
          state_d    = S_IDLE;
          wait_cnt_d = '0;
        end else begin
          stall      = 1'b1;
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Reset takes the request down in the same cycle, even mid-wait
    if (reset) begin
      req   = 1'b0;
      stall = 1'b0;
    end
  end

  assign dmem_req    = req;
  assign mem_stall   = stall;
  assign read_data_d = (acked & ~mem_mem_write) ? dmem_rdata : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      fault_q    <= fault_d;
    end
  end

  // Writeback register: clear beats hold; hold keeps forwarding valid for the frozen execute stage
  always_ff @(posedge clk) begin
    if (reset || wb_clear) begin
      wb_reg_write_q  <= 1'b0;
      wb_result_src_q <= 2'b00;
      wb_alu_result_q <= 32'h0;
      wb_read_data_q  <= 32'h0;
      wb_pc_plus_4_q  <= 32'h0;
      wb_imm_ext_q    <= 32'h0;
      wb_rd_q         <= 5'd0;
    end else if (!stall) begin
      wb_reg_write_q  <= mem_reg_write;
      wb_result_src_q <= mem_result_src;
      wb_alu_result_q <= mem_alu_result;
      wb_read_data_q  <= read_data_d;
      wb_pc_plus_4_q  <= mem_pc_plus_4;
      wb_imm_ext_q    <= mem_imm_ext;
      wb_rd_q         <= mem_rd;
    end
  end

  assign mem_fault     = fault_q;
  assign wb_reg_write  = wb_reg_write_q;
  assign wb_result_src = wb_result_src_q;
  assign wb_alu_result = wb_alu_result_q;
  assign wb_read_data  = wb_read_data_q;
  assign wb_pc_plus_4  = wb_pc_plus_4_q;
  assign wb_imm_ext    = wb_imm_ext_q;
  assign wb_rd         = wb_rd_q;

  always_comb begin
    case (wb_result_src_q)
      SRC_ALU:  wb_result = wb_alu_result_q;
      SRC_LOAD: wb_result = wb_read_data_q;
      SRC_PC4:  wb_result = wb_pc_plus_4_q;
      default:  wb_result = wb_imm_ext_q;
    endcase
  end

endmodule

// File: tb/tb_stage_memory.sv
// Bench for stage_memory: directed instruction stream, expected control/writeback values
// queued by the driver and compared by an independent monitor.
module tb_stage_memory;

  typedef struct packed {
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] result;
    logic [31:0] rdata;
    logic        fault;
  } wb_t;

  logic        clk = 1'b0;
  logic        reset, wb_clear;
  logic        mem_reg_write, mem_mem_write;
  logic [1:0]  mem_result_src;
  logic [31:0] mem_alu_result, mem_write_data, mem_pc_plus_4, mem_imm_ext;
  logic [4:0]  mem_rd;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        dmem_req, dmem_we, mem_stall, mem_fault;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        wb_reg_write;
  logic [1:0]  wb_result_src;
  logic [31:0] wb_alu_result, wb_read_data, wb_pc_plus_4, wb_imm_ext, wb_result;
  logic [4:0]  wb_rd;

  logic [2:0]  ctrl_q[$];
  wb_t         wb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  stage_memory #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .wb_clear(wb_clear),
    .mem_reg_write(mem_reg_write), .mem_mem_write(mem_mem_write),
    .mem_result_src(mem_result_src), .mem_alu_result(mem_alu_result),
    .mem_write_data(mem_write_data), .mem_pc_plus_4(mem_pc_plus_4),
    .mem_imm_ext(mem_imm_ext), .mem_rd(mem_rd),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .mem_stall(mem_stall), .mem_fault(mem_fault),
    .wb_reg_write(wb_reg_write), .wb_result_src(wb_result_src),
    .wb_alu_result(wb_alu_result), .wb_read_data(wb_read_data),
    .wb_pc_plus_4(wb_pc_plus_4), .wb_imm_ext(wb_imm_ext), .wb_rd(wb_rd),
    .wb_result(wb_result)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic wb_t mk(input logic rw, input logic [4:0] rd, input logic [31:0] res,
                             input logic [31:0] rdat, input logic flt);
    wb_t w;
    w.reg_write = rw;
    w.rd        = rd;
    w.result    = res;
    w.rdata     = rdat;
    w.fault     = flt;
    return w;
  endfunction

  task automatic instr(input logic rw, input logic mw, input logic [1:0] src,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd);
    mem_reg_write  = rw;
    mem_mem_write  = mw;
    mem_result_src = src;
    mem_alu_result = alu;
    mem_write_data = wd;
    mem_rd         = rd;
  endtask

  task automatic nop();
    instr(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
  endtask

  // One clock cycle: expected req/we/stall for this cycle, plus the wb state after the edge
  task automatic step(input logic er, input logic ew, input logic es, input logic pw, input wb_t w);
    ctrl_q.push_back({er, ew, es});
    if (pw) wb_q.push_back(w);
    @(posedge clk);
    #1;
  endtask

  // Monitor: control checked mid-cycle; wb popped when the register updates, else checked as held
  initial begin
    logic [2:0] c;
    wb_t        e;
    wb_t        last;
    logic       adv, got, have;
    last = '0;
    forever begin
      @(negedge clk);
      got = 1'b0;
      if (ctrl_q.size() > 0) begin
        c   = ctrl_q.pop_front();
        got = 1'b1;
        chk("dmem_req", 32'(dmem_req), 32'(c[2]));
        if (c[2]) chk("dmem_we", 32'(dmem_we), 32'(c[1]));
        chk("mem_stall", 32'(mem_stall), 32'(c[0]));
      end
      adv = reset | wb_clear | ~mem_stall;
      @(posedge clk);
      #1;
      if (got) begin
        have = 1'b1;
        e    = last;
        if (adv) begin
          if (wb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            have = 1'b0;
            $display("FAIL wb_update: unexpected writeback update at %0t", $time);
          end else begin
            e    = wb_q.pop_front();
            last = e;
          end
        end
        if (have) begin
          chk("wb_reg_write", 32'(wb_reg_write), 32'(e.reg_write));
          chk("wb_rd", 32'(wb_rd), 32'(e.rd));
          chk("wb_result", wb_result, e.result);
          chk("wb_read_data", wb_read_data, e.rdata);
          chk("mem_fault", 32'(mem_fault), 32'(e.fault));
        end
      end
    end
  end

  initial begin
    reset         = 1'b1;
    wb_clear      = 1'b0;
    nop();
    mem_pc_plus_4 = 32'h0000_0044;
    mem_imm_ext   = 32'hABCD_0000;
    dmem_rdata    = 32'h0;
    dmem_ack      = 1'b0;
    @(posedge clk);
    #1;

    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1, mk(1'b0, 5'd0, 32'h0, 32'h0, 1'b0));
    reset = 1'b0;

    // ALU op: no request, 1-cycle latency
    instr(1'b1, 1'b0, 2'b00, 32'h0000_1234, 32'h0, 5'd5);
    step(1'b0, 1'b0, 1'b0, 1'b1, mk(1'b1, 5'd5, 32'h0000_1234, 32'h0, 1'b0));

    // Zero-wait load
    instr(1'b1, 1'b0, 2'b01, 32'h0000_0100, 32'h0, 5'd6);
    dmem_rdata = 32'hDEAD_BEEF;
    dmem_ack   = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b1, mk(1'b1, 5'd6, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0));

    // Store acked after 3 wait cycles
    instr(1'b0, 1'b1, 2'b00, 32'h0000_0200, 32'hCAFE_F00D, 5'd0);
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0, '0);
    dmem_ack = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b1, mk(1'b0, 5'd0, 32'h0000_0200, 32'h0, 1'b0));

    // Load with wb_clear during the stall
    instr(1'b1, 1'b0, 2'b01, 32'h0000_0300, 32'h0, 5'd7);
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h1111_2222;
    wb_clear   = 1'b1;
    step(1'b1, 1'b0, 1'b1, 1'b1, mk(1'b0, 5'd0, 32'h0, 32'h0, 1'b0));
    wb_clear = 1'b0;
    step(1'b1, 1'b0, 1'b1, 1'b0, '0);
    dmem_ack = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b1, mk(1'b1, 5'd7, 32'h1111_2222, 32'h1111_2222, 1'b0));

    // Stray ack on a PC+4 op is ignored
    instr(1'b1, 1'b0, 2'b10, 32'h0000_0008, 32'h0, 5'd8);
    dmem_rdata = 32'hFFFF_FFFF;
    step(1'b0, 1'b0, 1'b0, 1'b1, mk(1'b1, 5'd8, 32'h0000_0044, 32'h0, 1'b0));
    dmem_ack = 1'b0;

    // Immediate select
    instr(1'b1, 1'b0, 2'b11, 32'h0000_000C, 32'h0, 5'd9);
    step(1'b0, 1'b0, 1'b0, 1'b1, mk(1'b1, 5'd9, 32'hABCD_0000, 32'h0, 1'b0));

    // Misaligned load: no request, fault, data 0 even with ack present
    instr(1'b1, 1'b0, 2'b01, 32'h0000_0102, 32'h0, 5'd11);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h0000_5555;
    step(1'b0, 1'b0, 1'b0, 1'b1, mk(1'b1, 5'd11, 32'h0, 32'h0, 1'b1));
    dmem_ack = 1'b0;

    // Misaligned store dropped, fault stays
    instr(1'b0, 1'b1, 2'b00, 32'h0000_0203, 32'h0000_0077, 5'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, mk(1'b0, 5'd0, 32'h0000_0203, 32'h0, 1'b1));
    instr(1'b1, 1'b0, 2'b00, 32'h0000_0004, 32'h0, 5'd3);
    step(1'b0, 1'b0, 1'b0, 1'b1, mk(1'b1, 5'd3, 32'h0000_0004, 32'h0, 1'b1));

    // Reset clears the sticky fault
    reset = 1'b1;
    nop();
    step(1'b0, 1'b0, 1'b0, 1'b1, mk(1'b0, 5'd0, 32'h0, 32'h0, 1'b0));
    reset = 1'b0;

    // Ack in the timeout cycle wins: no fault
    instr(1'b1, 1'b0, 2'b01, 32'h0000_0500, 32'h0, 5'd12);
    dmem_rdata = 32'h0BAD_F00D;
    repeat (4) step(1'b1, 1'b0, 1'b1, 1'b0, '0);
    dmem_ack = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b1, mk(1'b1, 5'd12, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0));
    dmem_ack = 1'b0;

    // Timeout: stall exactly 4 cycles, data 0, fault set
    instr(1'b1, 1'b0, 2'b01, 32'h0000_0400, 32'h0, 5'd10);
    dmem_rdata = 32'h9999_9999;
    repeat (4) step(1'b1, 1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b1, mk(1'b1, 5'd10, 32'h0, 32'h0, 1'b1));
    nop();
    step(1'b0, 1'b0, 1'b0, 1'b1, mk(1'b0, 5'd0, 32'h0, 32'h0, 1'b1));

    // Reset in the second WAIT cycle
    instr(1'b1, 1'b0, 2'b01, 32'h0000_0600, 32'h0, 5'd13);
    step(1'b1, 1'b0, 1'b1, 1'b0, '0);
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1, mk(1'b0, 5'd0, 32'h0, 32'h0, 1'b0));
    reset = 1'b0;
    nop();
    step(1'b0, 1'b0, 1'b0, 1'b1, mk(1'b0, 5'd0, 32'h0, 32'h0, 1'b0));

    repeat (2) @(posedge clk);
    #2;
    chk("ctrl_queue_left", 32'(ctrl_q.size()), 32'h0);
    chk("wb_queue_left", 32'(wb_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
